set_assoc_cache: RTL and testbench
==================================

// Module: set_assoc_cache
// PURPOSE
// - Parametrised N-way set-associative cache tag/state model with true-LRU replacement and built-in hit/miss statistics.
// - Sits between the trace command stream and the next-level (L2) cache; it is instanced once per instruction or data side.
// - Adds a valid/ready request handshake, an invalidate op, a multi-cycle clear op and an L2 request strobe.
// PARAMETERS
// - ADDR_W      32  byte-address width
// - SETS        64  number of sets; power of 2, >=2
// - WAYS        4   associativity; power of 2, >=2
// - LINE_BYTES  64  line size; power of 2. OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W
// PORTS
// - clk        in   1           clock, rising edge
// - clear      in   1           synchronous active-high reset
// - req_valid  in   1           request present
// - req_ready  out  1           block can accept; high only in IDLE
// - req_op     in   4           0 data read, 1 data write, 2 instr fetch, 3 invalidate, 8 clear; all other codes are no-op
// - req_addr   in   ADDR_W      byte address
// - resp_valid out  1           one-cycle pulse, request complete
// - resp_hit   out  1           lookup hit; valid with resp_valid; 0 for op 3/8/no-op
// - l2_valid   out  1           one-cycle L2 request strobe; no backpressure
// - l2_write   out  1           1=write to L2, 0=read (fill)
// - l2_addr    out  ADDR_W-OFF_W line address to L2 (26 bits at default)
// - hit_cnt, miss_cnt, read_cnt, write_cnt  out  32  statistics
// BEHAVIOUR
// - Reset (clear=1 at posedge): all valid/dirty bits 0; LRU ages per set = way index; counters 0; req_ready=1; resp_valid, resp_hit, l2_valid, l2_write 0; l2_addr 0; FSM -> IDLE. clear overrides any in-flight op, including FLUSH.
// - FSM: IDLE -> LOOKUP -> UPDATE [-> FILL] -> IDLE; op 8: IDLE -> FLUSH -> IDLE.
// - Accept on req_valid&req_ready in IDLE; op/addr are registered.
// - LOOKUP: compare the tag against all ways of the indexed set; record the hit way; pick the victim = lowest-index invalid way, else the way with age==WAYS-1.
// - UPDATE: write tag/valid/LRU; drive the L2 strobe. resp_valid asserts exactly 2 cycles after acceptance (3 when FILL is used).
// - LRU: on access to way w with age a, set w's age to 0 and increment every way in the set whose age is < a. Ages stay a permutation of 0..WAYS-1. Invalidate leaves ages unchanged.
// - Read/fetch miss: allocate the victim; l2_valid=1, l2_write=0, l2_addr={tag,idx}.
// - Counters: read_cnt counts ops 0 and 2; write_cnt counts op 1. hit_cnt and miss_cnt count ops 0, 1 and 2 only. All counters saturate at 32'hFFFF_FFFF.
// - Op 3: clear the valid bit of the matching way, if any. No L2 traffic; no counter change.
// - Op 8: zero the counters on entry. FLUSH walks sets 0..SETS-1, one per cycle, clearing valid/dirty and reloading ages. req_ready=0 for the full walk. resp_valid pulses on the cycle after the last set. No writebacks are issued.
// - No-op codes: resp_valid 2 cycles after accept, resp_hit=0, no side effects.
// - The new request may be accepted in the cycle after resp_valid.
// CONFIGURATION
// - Macro CACHE_WRITEBACK_EN defined: write-back, write-allocate, with a dirty bit per line.
//   - Write hit: set dirty; no L2 traffic.
//   - Write miss: allocate and set dirty.
//   - Any miss with a valid dirty victim: UPDATE issues l2_write=1 with the victim line address, then FILL issues the l2 read; resp_valid is raised in FILL.
//   - Op 3 drops dirty data without a writeback.
// - Macro undefined: write-through, no-allocate; no dirty storage; FILL is never used.
//   - Write hit: update LRU and issue l2_write=1.
//   - Write miss: issue l2_write=1 only, with no allocation.
// STRUCTURE
// - Package cache_pkg: op-code localparams (OP_READ=0, OP_WRITE=1, OP_FETCH=2, OP_INVAL=3, OP_CLEAR=8), FSM state enum, and the log2-derived widths.
// - Sub-module cache_lru_set: combinational per-set age update (inputs: ages, accessed way; outputs: new ages, LRU way). One instance in the top.
// TESTING
// - Read 0x0000_1000 twice -> 1st: resp_hit=0, l2 read l2_addr=0x40. 2nd: resp_hit=1. Counters: hit=1, miss=1, read=2.
// - Read 0x0000,0x1000,0x2000,0x3000 (set 0); read 0x0000; read 0x4000 -> 0x1000 is evicted; re-read of 0x1000 misses and 0x0000 hits.
// - Without WB: write 0x2040 -> l2_write=1, l2_addr=0x81; a following read of 0x2040 misses. With WB: write 0x0000, then fill set 0 with 4 other tags -> on the last fill, l2 write 0x0 then l2 read; response 3 cycles after accept.
// - Read 0x1000, op 3 at 0x1000, read 0x1000 -> 2nd read misses; the invalidate leaves all counters unchanged.
// - After traffic, op 8 -> counters 0, req_ready low for 64 cycles, resp_valid on cycle 65; every subsequent read misses.
// - Assert clear in LOOKUP and mid-FLUSH -> next cycle: req_ready=1, counters 0, no resp_valid/l2_valid pulses; the next read misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared op codes, FSM states, default geometry and helpers for the set-associative cache.
package cache_pkg;

    localparam logic [3:0] OP_READ  = 4'd0;
    localparam logic [3:0] OP_WRITE = 4'd1;
    localparam logic [3:0] OP_FETCH = 4'd2;
    localparam logic [3:0] OP_INVAL = 4'd3;
    localparam logic [3:0] OP_CLEAR = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_UPDATE,
        ST_FILL,
        ST_FLUSH
    } state_e;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_SETS       = 64;
    localparam int DEF_WAYS       = 4;
    localparam int DEF_LINE_BYTES = 64;
    localparam int DEF_OFF_W      = $clog2(DEF_LINE_BYTES);
    localparam int DEF_IDX_W      = $clog2(DEF_SETS);
    localparam int DEF_TAG_W      = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cache_lru_set.sv
// Combinational true-LRU age update for one set; also reports the oldest way.
module cache_lru_set #(
    parameter int WAYS  = 4,
    parameter int AGE_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages_i,
    input  logic [AGE_W-1:0]           way_i,
    output logic [WAYS-1:0][AGE_W-1:0] ages_o,
    output logic [AGE_W-1:0]           lru_o
);

    logic [AGE_W-1:0] acc_age;

    always_comb begin
        acc_age = ages_i[way_i];
        lru_o   = '0;
        ages_o  = ages_i;
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == way_i)
                ages_o[w] = '0;
            else if (ages_i[w] < acc_age)
                ages_o[w] = ages_i[w] + AGE_W'(1);
            if (ages_i[w] == AGE_W'(WAYS - 1))
                lru_o = AGE_W'(w);
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative tag/state model with true LRU and hit/miss statistics.
// Define CACHE_WRITEBACK_EN for write-back/write-allocate; default is write-through/no-allocate.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 4,
    parameter int LINE_BYTES = 64
) (
    input  logic                           clk,
    input  logic                           clear,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [3:0]                     req_op,
    input  logic [ADDR_W-1:0]              req_addr,
    output logic                           resp_valid,
    output logic                           resp_hit,
    output logic                           l2_valid,
    output logic                           l2_write,
    output logic [ADDR_W-$clog2(LINE_BYTES)-1:0] l2_addr,
    output logic [31:0]                    hit_cnt,
    output logic [31:0]                    miss_cnt,
    output logic [31:0]                    read_cnt,
    output logic [31:0]                    write_cnt
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int AGE_W = $clog2(WAYS);
    localparam int LA_W  = ADDR_W - OFF_W;

    state_e state_q, state_d;

    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_mem_q;
    logic [SETS-1:0][WAYS-1:0]            valid_q;
    logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_q;
`ifdef CACHE_WRITEBACK_EN
    logic [SETS-1:0][WAYS-1:0]            dirty_q;
    logic                                 vdirty_q;
    logic [TAG_W-1:0]                     vtag_q;
`endif

    logic [3:0]       op_q;
    logic [TAG_W-1:0] rtag_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] flush_q;
    logic             hit_q;
    logic [AGE_W-1:0] way_q;

    logic             resp_valid_q, resp_hit_q, l2_valid_q, l2_write_q;
    logic [LA_W-1:0]  l2_addr_q;
    logic [31:0]      hit_cnt_q, miss_cnt_q, read_cnt_q, write_cnt_q;

    logic             hit_c, inv_c, is_acc_c, alloc_c, go_fill_c;
    logic [AGE_W-1:0] hit_way_c, inv_way_c, victim_c, lru_way;
    logic [WAYS-1:0][AGE_W-1:0] new_ages;
    logic             unused_off;

    assign unused_off = ^req_addr[OFF_W-1:0];

    cache_lru_set #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
        .ages_i (age_q[idx_q]),
        .way_i  (way_q),
        .ages_o (new_ages),
        .lru_o  (lru_way)
    );

    // Descending scan so the lowest matching / invalid way wins.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        inv_c     = 1'b0;
        inv_way_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx_q][w] && tag_mem_q[idx_q][w] == rtag_q) begin
                hit_c     = 1'b1;
                hit_way_c = AGE_W'(w);
            end
            if (!valid_q[idx_q][w]) begin
                inv_c     = 1'b1;
                inv_way_c = AGE_W'(w);
            end
        end
        victim_c = inv_c ? inv_way_c : lru_way;
    end

    always_comb begin
        is_acc_c = (op_q == OP_READ) || (op_q == OP_WRITE) || (op_q == OP_FETCH);
`ifdef CACHE_WRITEBACK_EN
        alloc_c   = is_acc_c && !hit_q;
        go_fill_c = alloc_c && vdirty_q;
`else
        alloc_c   = is_acc_c && !hit_q && (op_q != OP_WRITE);
        go_fill_c = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = (req_op == OP_CLEAR) ? ST_FLUSH : ST_LOOKUP;
            ST_LOOKUP: state_d = ST_UPDATE;
            ST_UPDATE: state_d = go_fill_c ? ST_FILL : ST_IDLE;
            ST_FILL:   state_d = ST_IDLE;
            ST_FLUSH:  if (flush_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AGE_W'(w);
`ifdef CACHE_WRITEBACK_EN
                    dirty_q[s][w] <= 1'b0;
`endif
                end
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            l2_valid_q   <= 1'b0;
            l2_write_q   <= 1'b0;
            l2_addr_q    <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            read_cnt_q   <= '0;
            write_cnt_q  <= '0;
            flush_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            l2_valid_q   <= 1'b0;
            l2_write_q   <= 1'b0;
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    op_q    <= req_op;
                    rtag_q  <= req_addr[ADDR_W-1 -: TAG_W];
                    idx_q   <= req_addr[OFF_W +: IDX_W];
                    flush_q <= '0;
                    if (req_op == OP_CLEAR) begin
                        hit_cnt_q   <= '0;
                        miss_cnt_q  <= '0;
                        read_cnt_q  <= '0;
                        write_cnt_q <= '0;
                    end
                end
                ST_LOOKUP: begin
                    hit_q <= hit_c;
                    way_q <= hit_c ? hit_way_c : victim_c;
`ifdef CACHE_WRITEBACK_EN
                    vdirty_q <= valid_q[idx_q][victim_c] && dirty_q[idx_q][victim_c];
                    vtag_q   <= tag_mem_q[idx_q][victim_c];
`endif
                end
                ST_UPDATE: begin
                    resp_valid_q <= !go_fill_c;
                    if (is_acc_c) begin
                        if (hit_q) hit_cnt_q  <= sat_inc(hit_cnt_q);
                        else       miss_cnt_q <= sat_inc(miss_cnt_q);
                        if (op_q == OP_WRITE) write_cnt_q <= sat_inc(write_cnt_q);
                        else                  read_cnt_q  <= sat_inc(read_cnt_q);
                        resp_hit_q <= hit_q;
                        if (hit_q || alloc_c) age_q[idx_q] <= new_ages;
                    end
                    if (alloc_c) begin
                        tag_mem_q[idx_q][way_q] <= rtag_q;
                        valid_q[idx_q][way_q]   <= 1'b1;
                    end
`ifdef CACHE_WRITEBACK_EN
                    if (is_acc_c && op_q == OP_WRITE) dirty_q[idx_q][way_q] <= 1'b1;
                    else if (alloc_c)                 dirty_q[idx_q][way_q] <= 1'b0;
                    // A dirty victim goes out first; the fill read follows from FILL.
                    if (alloc_c) begin
                        l2_valid_q <= 1'b1;
                        l2_write_q <= vdirty_q;
                        l2_addr_q  <= vdirty_q ? {vtag_q, idx_q} : {rtag_q, idx_q};
                    end
`else
                    if (is_acc_c && op_q == OP_WRITE) begin
                        l2_valid_q <= 1'b1;
                        l2_write_q <= 1'b1;
                        l2_addr_q  <= {rtag_q, idx_q};
                    end else if (alloc_c) begin
                        l2_valid_q <= 1'b1;
                        l2_addr_q  <= {rtag_q, idx_q};
                    end
`endif
                    if (op_q == OP_INVAL && hit_q) begin
                        valid_q[idx_q][way_q] <= 1'b0;
`ifdef CACHE_WRITEBACK_EN
                        dirty_q[idx_q][way_q] <= 1'b0;
`endif
                    end
                end
                ST_FILL: begin
                    l2_valid_q   <= 1'b1;
                    l2_addr_q    <= {rtag_q, idx_q};
                    resp_valid_q <= 1'b1;
                end
                ST_FLUSH: begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_q[flush_q][w] <= 1'b0;
                        age_q[flush_q][w]   <= AGE_W'(w);
`ifdef CACHE_WRITEBACK_EN
                        dirty_q[flush_q][w] <= 1'b0;
`endif
                    end
                    flush_q <= flush_q + IDX_W'(1);
                    if (flush_q == IDX_W'(SETS - 1)) resp_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign l2_valid   = l2_valid_q;
    assign l2_write   = l2_write_q;
    assign l2_addr    = l2_addr_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;
    assign read_cnt   = read_cnt_q;
    assign write_cnt  = write_cnt_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache at default geometry (64 sets, 4 ways, 64-byte lines).
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        clear, req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic        resp_valid, resp_hit, l2_valid, l2_write;
    logic [25:0] l2_addr;
    logic [31:0] hit_cnt, miss_cnt, read_cnt, write_cnt;

    int checks = 0;
    int errors = 0;

    // Observations captured by the request driver
    int          lat, rdy_lo, l2_n;
    logic        got, rhit;
    logic        l2w [4];
    logic [25:0] l2a [4];

    always #5 clk = ~clk;

    set_assoc_cache dut (
        .clk(clk), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .l2_valid(l2_valid), .l2_write(l2_write), .l2_addr(l2_addr),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .read_cnt(read_cnt), .write_cnt(write_cnt)
    );

    task automatic do_reset();
        @(negedge clk);
        clear = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = '0;
        @(posedge clk); @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] addr);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_op = op; req_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; got = 1'b0; rhit = 1'b0; l2_n = 0;
        rdy_lo = req_ready ? 0 : 1;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (l2_valid && l2_n < 4) begin l2w[l2_n] = l2_write; l2a[l2_n] = l2_addr; l2_n++; end
            if (resp_valid) begin got = 1'b1; rhit = resp_hit; end
            else if (!req_ready) rdy_lo++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout op=%0d addr=%h: no resp_valid within 200 cycles", op, addr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_ready, resp_valid, resp_hit, l2_valid, l2_write} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl got=%b want=10000", {req_ready, resp_valid, resp_hit, l2_valid, l2_write});
        end
        checks++;
        if (l2_addr !== 26'd0 || hit_cnt !== 0 || miss_cnt !== 0 || read_cnt !== 0 || write_cnt !== 0) begin
            errors++; $display("FAIL reset_regs l2_addr=%h cnts=%0d/%0d/%0d/%0d want all 0", l2_addr, hit_cnt, miss_cnt, read_cnt, write_cnt);
        end
    endtask

    task automatic test_read_hit_miss();
        do_reset();
        send(4'd0, 32'h0000_1000);
        checks++;
        if (rhit !== 1'b0 || lat != 2) begin
            errors++; $display("FAIL rd1_resp hit=%b lat=%0d want hit=0 lat=2", rhit, lat);
        end
        checks++;
        if (l2_n != 1 || l2w[0] !== 1'b0 || l2a[0] !== 26'h40) begin
            errors++; $display("FAIL rd1_l2 n=%0d w=%b a=%h want n=1 w=0 a=40", l2_n, l2w[0], l2a[0]);
        end
        send(4'd0, 32'h0000_1000);
        checks++;
        if (rhit !== 1'b1 || l2_n != 0) begin
            errors++; $display("FAIL rd2_hit hit=%b l2_n=%0d want hit=1 l2_n=0", rhit, l2_n);
        end
        checks++;
        if (hit_cnt !== 1 || miss_cnt !== 1 || read_cnt !== 2 || write_cnt !== 0) begin
            errors++; $display("FAIL rd_counters h/m/r/w=%0d/%0d/%0d/%0d want 1/1/2/0", hit_cnt, miss_cnt, read_cnt, write_cnt);
        end
    endtask

    task automatic test_lru();
        do_reset();
        send(4'd0, 32'h0000_0000);
        send(4'd2, 32'h0000_1000);
        send(4'd0, 32'h0000_2000);
        send(4'd0, 32'h0000_3000);
        send(4'd0, 32'h0000_0000);
        checks++;
        if (rhit !== 1'b1) begin errors++; $display("FAIL lru_rehit0 hit=%b want 1", rhit); end
        send(4'd0, 32'h0000_4000);
        checks++;
        if (rhit !== 1'b0 || l2_n != 1 || l2a[0] !== 26'h100) begin
            errors++; $display("FAIL lru_fill4 hit=%b n=%0d a=%h want 0/1/100", rhit, l2_n, l2a[0]);
        end
        send(4'd0, 32'h0000_1000);
        checks++;
        if (rhit !== 1'b0) begin errors++; $display("FAIL lru_evicted hit=%b want 0", rhit); end
        send(4'd0, 32'h0000_0000);
        checks++;
        if (rhit !== 1'b1) begin errors++; $display("FAIL lru_kept hit=%b want 1", rhit); end
        checks++;
        if (read_cnt !== 8 || hit_cnt !== 2 || miss_cnt !== 6) begin
            errors++; $display("FAIL lru_counters r/h/m=%0d/%0d/%0d want 8/2/6", read_cnt, hit_cnt, miss_cnt);
        end
    endtask

`ifdef CACHE_WRITEBACK_EN
    task automatic test_writeback();
        do_reset();
        send(4'd1, 32'h0000_0000);
        checks++;
        if (l2_n != 1 || l2w[0] !== 1'b0 || l2a[0] !== 26'h0 || lat != 2) begin
            errors++; $display("FAIL wb_wmiss n=%0d w=%b a=%h lat=%0d want 1/0/0/2", l2_n, l2w[0], l2a[0], lat);
        end
        send(4'd0, 32'h0000_1000);
        send(4'd0, 32'h0000_2000);
        send(4'd0, 32'h0000_3000);
        send(4'd0, 32'h0000_4000);
        checks++;
        if (l2_n != 2 || l2w[0] !== 1'b1 || l2a[0] !== 26'h0 || l2w[1] !== 1'b0 || l2a[1] !== 26'h100) begin
            errors++; $display("FAIL wb_evict n=%0d w0=%b a0=%h w1=%b a1=%h want 2/1/0/0/100", l2_n, l2w[0], l2a[0], l2w[1], l2a[1]);
        end
        checks++;
        if (lat != 3 || rhit !== 1'b0) begin
            errors++; $display("FAIL wb_latency lat=%0d hit=%b want 3/0", lat, rhit);
        end
    endtask
`else
    task automatic test_write_through();
        do_reset();
        send(4'd1, 32'h0000_2040);
        checks++;
        if (rhit !== 1'b0 || l2_n != 1 || l2w[0] !== 1'b1 || l2a[0] !== 26'h81) begin
            errors++; $display("FAIL wt_wmiss hit=%b n=%0d w=%b a=%h want 0/1/1/81", rhit, l2_n, l2w[0], l2a[0]);
        end
        send(4'd0, 32'h0000_2040);
        checks++;
        if (rhit !== 1'b0 || l2_n != 1 || l2w[0] !== 1'b0 || l2a[0] !== 26'h81) begin
            errors++; $display("FAIL wt_noalloc hit=%b n=%0d w=%b a=%h want 0/1/0/81", rhit, l2_n, l2w[0], l2a[0]);
        end
        send(4'd1, 32'h0000_2040);
        checks++;
        if (rhit !== 1'b1 || l2_n != 1 || l2w[0] !== 1'b1 || l2a[0] !== 26'h81) begin
            errors++; $display("FAIL wt_whit hit=%b n=%0d w=%b a=%h want 1/1/1/81", rhit, l2_n, l2w[0], l2a[0]);
        end
        checks++;
        if (write_cnt !== 2 || read_cnt !== 1 || hit_cnt !== 1 || miss_cnt !== 2) begin
            errors++; $display("FAIL wt_counters w/r/h/m=%0d/%0d/%0d/%0d want 2/1/1/2", write_cnt, read_cnt, hit_cnt, miss_cnt);
        end
    endtask
`endif

    task automatic test_invalidate_noop();
        do_reset();
        send(4'd0, 32'h0000_1000);
        send(4'd3, 32'h0000_1000);
        checks++;
        if (rhit !== 1'b0 || l2_n != 0 || lat != 2) begin
            errors++; $display("FAIL inval_resp hit=%b n=%0d lat=%0d want 0/0/2", rhit, l2_n, lat);
        end
        checks++;
        if (hit_cnt !== 0 || miss_cnt !== 1 || read_cnt !== 1 || write_cnt !== 0) begin
            errors++; $display("FAIL inval_counters h/m/r/w=%0d/%0d/%0d/%0d want 0/1/1/0", hit_cnt, miss_cnt, read_cnt, write_cnt);
        end
        send(4'd0, 32'h0000_1000);
        checks++;
        if (rhit !== 1'b0) begin errors++; $display("FAIL inval_rereads hit=%b want 0", rhit); end
        send(4'd5, 32'h0000_1000);
        checks++;
        if (rhit !== 1'b0 || l2_n != 0 || lat != 2 || miss_cnt !== 2 || read_cnt !== 2) begin
            errors++; $display("FAIL noop hit=%b n=%0d lat=%0d m=%0d r=%0d want 0/0/2/2/2", rhit, l2_n, lat, miss_cnt, read_cnt);
        end
        send(4'd0, 32'h0000_1000);
        checks++;
        if (rhit !== 1'b1) begin errors++; $display("FAIL noop_kept hit=%b want 1", rhit); end
    endtask

    task automatic test_flush();
        do_reset();
        send(4'd0, 32'h0000_0000);
        send(4'd0, 32'h0000_0FC0);
        send(4'd0, 32'h0000_0000);
        send(4'd8, 32'h0000_0000);
        checks++;
        if (lat != 64 || rdy_lo != 64 || rhit !== 1'b0 || l2_n != 0) begin
            errors++; $display("FAIL flush_timing lat=%0d rdy_lo=%0d hit=%b n=%0d want 64/64/0/0", lat, rdy_lo, rhit, l2_n);
        end
        checks++;
        if (hit_cnt !== 0 || miss_cnt !== 0 || read_cnt !== 0 || write_cnt !== 0) begin
            errors++; $display("FAIL flush_counters h/m/r/w=%0d/%0d/%0d/%0d want 0", hit_cnt, miss_cnt, read_cnt, write_cnt);
        end
        send(4'd0, 32'h0000_0000);
        checks++;
        if (rhit !== 1'b0) begin errors++; $display("FAIL flush_set0 hit=%b want 0", rhit); end
        send(4'd0, 32'h0000_0FC0);
        checks++;
        if (rhit !== 1'b0 || miss_cnt !== 2) begin
            errors++; $display("FAIL flush_set63 hit=%b m=%0d want 0/2", rhit, miss_cnt);
        end
    endtask

    task automatic test_clear_midop();
        int pulses;
        // clear while LOOKUP is in flight
        do_reset();
        send(4'd0, 32'h0000_0FC0);
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0; req_addr = 32'h0000_5000;
        @(posedge clk); #1;
        req_valid = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || l2_valid !== 1'b0 || hit_cnt !== 0 || miss_cnt !== 0 || read_cnt !== 0) begin
            errors++; $display("FAIL clr_lookup rdy=%b rv=%b l2v=%b h/m/r=%0d/%0d/%0d want 1/0/0/0/0/0", req_ready, resp_valid, l2_valid, hit_cnt, miss_cnt, read_cnt);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (resp_valid || l2_valid) pulses++; end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL clr_lookup_quiet pulses=%0d want 0", pulses); end
        send(4'd0, 32'h0000_0FC0);
        checks++;
        if (rhit !== 1'b0) begin errors++; $display("FAIL clr_lookup_miss hit=%b want 0", rhit); end

        // clear in the middle of the flush walk
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd8; req_addr = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || l2_valid !== 1'b0 || miss_cnt !== 0) begin
            errors++; $display("FAIL clr_flush rdy=%b rv=%b l2v=%b m=%0d want 1/0/0/0", req_ready, resp_valid, l2_valid, miss_cnt);
        end
        pulses = 0;
        for (int i = 0; i < 70; i++) begin @(posedge clk); #1; if (resp_valid || l2_valid || !req_ready) pulses++; end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL clr_flush_quiet events=%0d want 0", pulses); end
        send(4'd0, 32'h0000_0FC0);
        checks++;
        if (rhit !== 1'b0 || miss_cnt !== 1) begin
            errors++; $display("FAIL clr_flush_miss hit=%b m=%0d want 0/1", rhit, miss_cnt);
        end
    endtask

    initial begin
        clear = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_addr = '0;
        test_reset();
        test_read_hit_miss();
        test_lru();
`ifdef CACHE_WRITEBACK_EN
        test_writeback();
`else
        test_write_through();
`endif
        test_invalidate_noop();
        test_flush();
        test_clear_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
